// File: rtl/mem_io_pkg.sv
// Shared types and default parameters for the CPU-side memory/IO bridge.
package mem_io_pkg;

  localparam int DEF_ADDR_W      = 20;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_NUM_IO      = 4;
  localparam int DEF_WAIT_CYCLES = 2;

  // Width of the ACCESS-phase counter; holds any legal WAIT_CYCLES (1..15).
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mem_io_sram_seq.sv
// Asynchronous-SRAM access sequencer: SETUP -> ACCESS (WAIT_CYCLES) -> DONE,
// with strobes, byte enables and data-bus direction decoded from the state.
module mem_io_sram_seq
  import mem_io_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic                idle,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_dq_out,
  output logic                sram_dq_oe,
  input  logic [DATA_W-1:0]   sram_dq_in,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [DATA_W/8-1:0] sram_be_n
);

  localparam int NB = DATA_W / 8;
  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(WAIT_CYCLES - 1);

  seq_state_t            state;
  seq_state_t            state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [NB-1:0]         be_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  last_access;

  assign last_access = (state == ACCESS) && (wait_cnt == LAST_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request fields are frozen at accept so the SRAM sees stable address,
  // enables and write data for the whole SETUP..DONE window.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_cnt <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        we_q    <= we;
        addr_q  <= addr;
        be_q    <= be;
        wdata_q <= wdata;
      end
      if (state == ACCESS) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (last_access) begin
        rdata_q <= we_q ? '0 : sram_dq_in;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    idle       = 1'b0;
    done       = 1'b0;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_be_n  = '1;
    sram_dq_oe = 1'b0;
    unique case (state)
      IDLE: begin
        idle = 1'b1;
        if (start) state_next = SETUP;
      end
      SETUP: begin
        sram_ce_n  = 1'b0;
        sram_be_n  = ~be_q;
        sram_dq_oe = we_q;
        state_next = ACCESS;
      end
      ACCESS: begin
        sram_ce_n  = 1'b0;
        sram_be_n  = ~be_q;
        sram_dq_oe = we_q;
        sram_oe_n  = we_q;
        sram_we_n  = ~we_q;
        if (wait_cnt == LAST_WAIT) state_next = DONE;
      end
      DONE: begin
        sram_ce_n  = 1'b0;
        sram_be_n  = ~be_q;
        sram_dq_oe = we_q;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign rdata       = rdata_q;

endmodule

// File: rtl/mem_io_bridge.sv
// CPU bridge: top-of-map IO channels answered in one cycle, everything else
// sent to async SRAM. Define MEM_IO_SYNC_IN_EN to synchronize io_in (2 flops).
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_IO      = DEF_NUM_IO,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W/8-1:0]        req_be,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [ADDR_W-1:0]          sram_addr,
  output logic [DATA_W-1:0]          sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [DATA_W-1:0]          sram_dq_in,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic [DATA_W/8-1:0]        sram_be_n,
  input  logic [NUM_IO*DATA_W-1:0]   io_in,
  output logic [NUM_IO*DATA_W-1:0]   io_out
);

  localparam int NB = DATA_W / 8;
  localparam int IW = $clog2(NUM_IO);

  logic                     accept;
  logic                     io_hit;
  logic [IW-1:0]            io_idx;
  logic                     seq_idle;
  logic                     seq_done;
  logic [DATA_W-1:0]        seq_rdata;
  logic [NUM_IO*DATA_W-1:0] io_src;
  logic [NUM_IO*DATA_W-1:0] io_out_q;
  logic                     io_rsp_q;
  logic [DATA_W-1:0]        io_rdata_q;

  assign io_hit    = &req_addr[ADDR_W-1:IW];
  assign io_idx    = req_addr[IW-1:0];
  assign req_ready = seq_idle;
  assign accept    = req_valid && req_ready;

`ifdef MEM_IO_SYNC_IN_EN
  logic [NUM_IO*DATA_W-1:0] io_sync1;
  logic [NUM_IO*DATA_W-1:0] io_sync2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      io_sync1 <= '0;
      io_sync2 <= '0;
    end else begin
      io_sync1 <= io_in;
      io_sync2 <= io_sync1;
    end
  end

  assign io_src = io_sync2;
`else
  assign io_src = io_in;
`endif

  // IO accesses never leave IDLE: the sequencer is bypassed and the response
  // is registered here, one cycle after accept.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      io_out_q   <= '0;
      io_rsp_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      io_rsp_q <= accept && io_hit;
      if (accept && io_hit) begin
        if (req_we) begin
          io_rdata_q <= '0;
          for (int b = 0; b < NB; b++) begin
            if (req_be[b]) begin
              io_out_q[int'(io_idx)*DATA_W + b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
          end
        end else begin
          io_rdata_q <= io_src[int'(io_idx)*DATA_W +: DATA_W];
        end
      end
    end
  end

  mem_io_sram_seq #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_sram_seq (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (accept && !io_hit),
    .we          (req_we),
    .addr        (req_addr),
    .be          (req_be),
    .wdata       (req_wdata),
    .idle        (seq_idle),
    .done        (seq_done),
    .rdata       (seq_rdata),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_be_n   (sram_be_n)
  );

  // An IO response and an SRAM completion cannot coincide: IO is only
  // accepted while the sequencer is idle.
  assign rsp_valid = io_rsp_q | seq_done;
  assign rsp_rdata = io_rsp_q ? io_rdata_q : (seq_done ? seq_rdata : '0);
  assign io_out    = io_out_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: behavioural SRAM, expected responses
// queued at accept and compared (data, latency, strobe activity) on completion.
module tb_mem_io_bridge;

  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 16;
  localparam int NUM_IO      = 4;
  localparam int WAIT_CYCLES = 2;
  localparam int NB          = DATA_W / 8;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    int                due;
    bit                sram;
    bit                we;
    logic [NB-1:0]     be_n;
  } exp_t;

  logic                     Clk = 1'b0;
  logic                     Reset;
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [ADDR_W-1:0]        req_addr;
  logic [NB-1:0]            req_be;
  logic [DATA_W-1:0]        req_wdata;
  logic                     rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic [ADDR_W-1:0]        sram_addr;
  logic [DATA_W-1:0]        sram_dq_out;
  logic                     sram_dq_oe;
  logic [DATA_W-1:0]        sram_dq_in;
  logic                     sram_ce_n;
  logic                     sram_oe_n;
  logic                     sram_we_n;
  logic [NB-1:0]            sram_be_n;
  logic [NUM_IO*DATA_W-1:0] io_in;
  logic [NUM_IO*DATA_W-1:0] io_out;

  exp_t              sb[$];
  exp_t              mon_e;
  int                n_tests = 0;
  int                n_fail  = 0;
  int                cyc     = 0;
  int                oe_cnt, we_cnt, dqoe_cnt, ce_cnt;
  logic [NB-1:0]     be_n_seen;
  logic [DATA_W-1:0] dev_mem [0:1023];
  logic [63:0]       io_model;

  mem_io_bridge #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NUM_IO      (NUM_IO),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_be      (req_be),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_be_n   (sram_be_n),
    .io_in       (io_in),
    .io_out      (io_out)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural async SRAM: reads while ce/oe are low, byte writes while ce/we are low.
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? dev_mem[sram_addr[9:0]] : '0;

  always @(posedge Clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < NB; b++) begin
        if (!sram_be_n[b]) dev_mem[sram_addr[9:0]][b*8 +: 8] <= sram_dq_out[b*8 +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: strobe activity is accumulated from accept to completion.
  always @(negedge Clk) begin
    if (!sram_oe_n) oe_cnt++;
    if (!sram_we_n) begin
      we_cnt++;
      be_n_seen = sram_be_n;
    end
    if (sram_dq_oe) dqoe_cnt++;
    if (!sram_ce_n) ce_cnt++;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_rsp", 64'(rsp_valid), 64'h0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        check("rsp_latency", 64'(cyc), 64'(mon_e.due));
        if (mon_e.sram) begin
          check("ready_in_done", 64'(req_ready), 64'h0);
          check("oe_cycles", 64'(oe_cnt), mon_e.we ? 64'h0 : 64'(WAIT_CYCLES));
          check("we_cycles", 64'(we_cnt), mon_e.we ? 64'(WAIT_CYCLES) : 64'h0);
          check("ce_cycles", 64'(ce_cnt), 64'(WAIT_CYCLES + 2));
          check("dq_oe_cycles", 64'(dqoe_cnt), mon_e.we ? 64'(WAIT_CYCLES + 2) : 64'h0);
          if (mon_e.we) check("be_n_at_we", 64'(be_n_seen), 64'(mon_e.be_n));
        end else begin
          check("io_no_strobe", 64'(ce_cnt), 64'h0);
        end
      end
    end
  end

  task automatic do_req(input bit we, input logic [ADDR_W-1:0] addr, input logic [NB-1:0] be,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata);
    exp_t e;
    bit   is_io;
    int   tries;
    is_io = &addr[ADDR_W-1:2];
    @(negedge Clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    tries     = 0;
    while (req_ready !== 1'b1 && tries < 20) begin
      @(negedge Clk);
      tries++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", 64'(req_ready), 64'h1);
      req_valid = 1'b0;
      return;
    end
    oe_cnt   = 0;
    we_cnt   = 0;
    dqoe_cnt = 0;
    ce_cnt   = 0;
    be_n_seen = '1;
    e.rdata = exp_rdata;
    e.due   = cyc + (is_io ? 1 : WAIT_CYCLES + 2);
    e.sram  = !is_io;
    e.we    = we;
    e.be_n  = ~be;
    sb.push_back(e);
    @(posedge Clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("rsp_timeout", 64'(sb.size()), 64'h0);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    io_in     = {16'h4444, 16'h3333, 16'h00C3, 16'h1111};
    io_model  = '0;
    for (int i = 0; i < 1024; i++) dev_mem[i] = '0;
    dev_mem[10'h100] = 16'h5A5A;

    repeat (3) @(negedge Clk);
    check("rst_ready", 64'(req_ready), 64'h1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
    check("rst_strobes", 64'({sram_ce_n, sram_oe_n, sram_we_n}), 64'h7);
    check("rst_be_n", 64'(sram_be_n), 64'h3);
    check("rst_dq_oe", 64'(sram_dq_oe), 64'h0);
    check("rst_sram_addr", 64'(sram_addr), 64'h0);
    check("rst_io_out", io_out, 64'h0);
    Reset = 1'b0;

    // IO writes: full word to channel 3, byte merge on channel 0, be=0 no-op.
    do_req(1'b1, 20'hFFFFF, 2'b11, 16'hBEEF, 16'h0000);
    wait_idle();
    io_model[48 +: 16] = 16'hBEEF;
    check("io_wr_ch3", io_out, io_model);

    do_req(1'b1, 20'hFFFFC, 2'b11, 16'hFFFF, 16'h0000);
    do_req(1'b1, 20'hFFFFC, 2'b01, 16'h12AB, 16'h0000);
    wait_idle();
    io_model[0 +: 16] = 16'hFFAB;
    check("io_wr_ch0_byte", io_out, io_model);

    do_req(1'b1, 20'hFFFFD, 2'b00, 16'h5555, 16'h0000);
    wait_idle();
    check("io_wr_be0", io_out, io_model);

    // IO reads; after a change of io_in the synchronized build still returns the old value.
    do_req(1'b0, 20'hFFFFD, 2'b11, 16'h0000, 16'h00C3);
    wait_idle();
    io_in[16 +: 16] = 16'h0077;
`ifdef MEM_IO_SYNC_IN_EN
    do_req(1'b0, 20'hFFFFD, 2'b11, 16'h0000, 16'h00C3);
`else
    do_req(1'b0, 20'hFFFFD, 2'b11, 16'h0000, 16'h0077);
`endif
    wait_idle();
    do_req(1'b0, 20'hFFFFD, 2'b11, 16'h0000, 16'h0077);
    wait_idle();
    do_req(1'b0, 20'hFFFFE, 2'b11, 16'h0000, 16'h3333);
    wait_idle();

    // SRAM read, partial write, read-back, and a be=0 write that must change nothing.
    do_req(1'b0, 20'h00100, 2'b11, 16'h0000, 16'h5A5A);
    wait_idle();
    do_req(1'b1, 20'h00200, 2'b10, 16'h1234, 16'h0000);
    wait_idle();
    check("sram_mem_200", 64'(dev_mem[10'h200]), 64'h1200);
    do_req(1'b0, 20'h00200, 2'b11, 16'h0000, 16'h1200);
    wait_idle();
    do_req(1'b1, 20'h00100, 2'b00, 16'hFFFF, 16'h0000);
    wait_idle();
    do_req(1'b0, 20'h00100, 2'b11, 16'h0000, 16'h5A5A);
    wait_idle();

    // Back-to-back mixed traffic; each accept waits for req_ready.
    do_req(1'b0, 20'h00100, 2'b11, 16'h0000, 16'h5A5A);
    do_req(1'b1, 20'hFFFFE, 2'b11, 16'hCAFE, 16'h0000);
    do_req(1'b0, 20'h00200, 2'b11, 16'h0000, 16'h1200);
    wait_idle();
    io_model[32 +: 16] = 16'hCAFE;
    check("b2b_io_out", io_out, io_model);

    // Reset in the second ACCESS cycle aborts the read with no response.
    do_req(1'b0, 20'h00100, 2'b11, 16'h0000, 16'h5A5A);
    repeat (3) @(negedge Clk);
    check("abort_in_access", 64'(sram_oe_n), 64'h0);
    Reset = 1'b1;
    sb.delete();
    @(negedge Clk);
    check("abort_strobes", 64'({sram_ce_n, sram_oe_n, sram_we_n}), 64'h7);
    check("abort_be_n", 64'(sram_be_n), 64'h3);
    check("abort_dq_oe", 64'(sram_dq_oe), 64'h0);
    check("abort_ready", 64'(req_ready), 64'h1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'h0);
    check("abort_io_out", io_out, 64'h0);
    Reset = 1'b0;
    io_model = '0;
    repeat (4) @(negedge Clk);

    // Reset wins over a simultaneous IO write accept.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 20'hFFFFE;
    req_be    = 2'b11;
    req_wdata = 16'hAAAA;
    Reset     = 1'b1;
    @(posedge Clk);
    #1;
    req_valid = 1'b0;
    Reset     = 1'b0;
    @(negedge Clk);
    check("rst_accept_rsp", 64'(rsp_valid), 64'h0);
    check("rst_accept_io_out", io_out, io_model);

    do_req(1'b0, 20'h00100, 2'b11, 16'h0000, 16'h5A5A);
    wait_idle();
    repeat (2) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 16, data width in bits, multiple of 8; NB = DATA_W/8.
REQ-003 SHALL have parameter NUM_IO, default 4, power of two >= 2, IO channel count; IW = clog2(NUM_IO).
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, range 1..15, SRAM strobe-active cycles.
REQ-005 SHALL have port Clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports req_valid  input  1  and req_ready  output  1  for the CPU request handshake.
REQ-008 SHALL have ports req_we  input  1 (1 = write), req_addr  input  ADDR_W, req_be  input  NB, req_wdata  input  DATA_W.
REQ-009 SHALL have ports rsp_valid  output  1 (one-cycle completion pulse) and rsp_rdata  output  DATA_W.
REQ-010 SHALL have ports sram_addr  output  ADDR_W, sram_dq_out  output  DATA_W, sram_dq_oe  output  1, sram_dq_in  input  DATA_W.
REQ-011 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n  output  1 each, and sram_be_n  output  NB.
REQ-012 SHALL have ports io_in  input  NUM_IO*DATA_W (switch channels) and io_out  output  NUM_IO*DATA_W (display/LED registers).

Function
REQ-013 SHALL decode an IO hit when req_addr[ADDR_W-1:IW] is all ones; channel index = req_addr[IW-1:0]; all other addresses go to SRAM.
REQ-014 SHALL accept a request on a cycle with req_valid and req_ready both high; req_ready SHALL be high only in state IDLE.
REQ-015 SHALL, on an IO hit, return to IDLE with rsp_valid high exactly 1 cycle after accept, without touching SRAM strobes.
REQ-016 SHALL, on an IO read, return io_in channel[index] on rsp_rdata; on an IO write, update only io_out channel[index] bytes whose req_be bit is 1.
REQ-017 SHALL run SRAM accesses through the states IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_CYCLES cycles) -> DONE (1 cycle) -> IDLE.
REQ-018 SHALL latch address, data, byte enables and direction at accept, and hold sram_addr and sram_be_n = ~be stable from SETUP through DONE.
REQ-019 SHALL drive sram_ce_n low in SETUP, ACCESS and DONE; sram_oe_n low (reads) or sram_we_n low (writes) only in ACCESS.
REQ-020 SHALL drive sram_dq_oe high for writes from SETUP through DONE, so data is stable on both sides of the sram_we_n pulse.
REQ-021 SHALL capture sram_dq_in on the last ACCESS cycle and present it with rsp_valid in DONE; SRAM latency = WAIT_CYCLES+2 cycles from accept.
REQ-022 SHALL return rsp_rdata = 0 on every write completion.
REQ-023 SHALL acknowledge a write with req_be = 0 normally while changing no SRAM byte or io_out bit.
REQ-024 SHALL deassert req_ready during DONE; the next accept is possible in the IDLE cycle that follows.

Reset
REQ-025 SHALL, while Reset is high at a clock edge, enter IDLE and set io_out = 0, rsp_valid = 0, rsp_rdata = 0, sram_ce_n/oe_n/we_n = 1, sram_be_n all ones, sram_dq_oe = 0, sram_addr = 0.
REQ-026 SHALL abort any in-flight access on reset with no rsp_valid issued; reset SHALL take priority over a simultaneous accept.

Configuration
REQ-027 SHALL, when MEM_IO_SYNC_IN_EN is defined, pass io_in through a 2-flop synchronizer (reset to 0), so IO reads reflect io_in from 2 cycles earlier.
REQ-028 SHALL, when MEM_IO_SYNC_IN_EN is undefined, sample io_in directly at accept with no synchronizer flops.

Structure
REQ-029 SHALL place the state enum (IDLE, SETUP, ACCESS, DONE) and the default-parameter constants in package mem_io_pkg.
REQ-030 SHALL implement the SRAM FSM and strobe generation in sub-module mem_io_sram_seq; decode, IO registers and response muxing SHALL stay in the top module.

Verification
REQ-031 SHALL cover: IO write addr 0xFFFFF, be=2'b11, data 0xBEEF -> io_out channel 3 = 0xBEEF; rsp_valid 1 cycle after accept.
REQ-032 SHALL cover: IO write channel 0, be=2'b01, data 0x12AB over 0xFFFF -> io_out channel 0 = 0xFFAB.
REQ-033 SHALL cover: SRAM read addr 0x00100, WAIT_CYCLES=2, model returns 0x5A5A -> oe_n low exactly 2 cycles; rsp_rdata 0x5A5A 4 cycles after accept.
REQ-034 SHALL cover: SRAM write addr 0x00200, data 0x1234, be=2'b10 -> we_n low 2 cycles, sram_be_n = 2'b01, dq_oe high SETUP..DONE, rsp_rdata 0.
REQ-035 SHALL cover: Reset asserted in second ACCESS cycle -> next cycle all strobes high, req_ready 1, no rsp_valid; io_out 0.
REQ-036 SHALL cover: io_in channel 1 = 0x00C3 with MEM_IO_SYNC_IN_EN defined -> IO read returns 0x00C3 only once io_in has been stable for 2 cycles before accept.
